// File: rtl/grom_mem_arbiter.sv
// rtl/grom_mem_arbiter.sv - two-master round-robin arbiter with burst lock for a shared synchronous RAM
module grom_mem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);
  localparam logic [3:0] BURST_SAT = 4'hF;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic                we_nxt;
  logic                ack0_nxt, ack1_nxt;
  logic                owner, owner_nxt;
  logic                last, last_nxt;
  logic [3:0]          burst_cnt, cnt_nxt;
  logic                win;
  logic                req_last, lock_last;

  // Request and lock of the master that won the previous grant
  assign req_last  = last ? m1_req  : m0_req;
  assign lock_last = last ? m1_lock : m0_lock;

  // Read data is a straight pass of the RAM output; meaningful only in the ack cycle
  assign rdata = mem_rdata;
  assign busy  = (state != ST_IDLE);

  // State and registered RAM/ack outputs; reset abandons any in-flight access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      owner     <= 1'b0;
      last      <= 1'b1;
      burst_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_we    <= we_nxt;
      m0_ack    <= ack0_nxt;
      m1_ack    <= ack1_nxt;
      owner     <= owner_nxt;
      last      <= last_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  // Next-state, arbitration and output decode; requests are only looked at in IDLE
  always_comb begin
    state_nxt = state;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    we_nxt    = 1'b0;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    owner_nxt = owner;
    last_nxt  = last;
    cnt_nxt   = burst_cnt;
    win       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          // Lock keeps the previous winner until the burst limit, then round-robin
          if (req_last && lock_last && (burst_cnt < BURST_LIM)) begin
            win = last;
          end else if (m0_req && m1_req) begin
            win = ~last;
          end else begin
            win = m1_req;
          end
          addr_nxt  = win ? m1_addr  : m0_addr;
          wdata_nxt = win ? m1_wdata : m0_wdata;
          we_nxt    = win ? m1_we    : m0_we;
          owner_nxt = win;
          last_nxt  = win;
          if (win == last) begin
            cnt_nxt = (burst_cnt == BURST_SAT) ? burst_cnt : burst_cnt + 4'd1;
          end else begin
            cnt_nxt = 4'd1;
          end
          state_nxt = ST_MEM;
        end
      end
      ST_MEM: begin
        ack0_nxt  = ~owner;
        ack1_nxt  = owner;
        state_nxt = ST_ACK;
      end
      ST_ACK: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_grom_mem_arbiter.sv
// tb/tb_grom_mem_arbiter.sv - directed table-driven bench for grom_mem_arbiter
module tb_grom_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_lock;
  logic [11:0] m0_addr;
  logic [7:0]  m0_wdata;
  logic        m0_ack;
  logic        m1_req, m1_we, m1_lock;
  logic [11:0] m1_addr;
  logic [7:0]  m1_wdata;
  logic        m1_ack;
  logic [7:0]  rdata;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  logic        preload;
  logic [7:0]  ram [0:4095];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        mst;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic        chk_rd;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [8];

  grom_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous 4K x 8 RAM model with a preload port used during reset
  always @(posedge clk) begin
    if (preload) begin
      ram[12'h123] <= 8'h5A;
      ram[12'h456] <= 8'h11;
      ram[12'h010] <= 8'hB1;
      ram[12'h020] <= 8'hC3;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_reqs();
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_mem(input string name);
    int n;
    n = 0;
    while (!busy && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_reach_mem"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic do_access(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.mst == 1'b0) begin
      m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
    end else begin
      m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
    end
    @(negedge clk);
    wait_mem(tag);
    chk({tag, "_mem_addr"}, {20'd0, mem_addr}, {20'd0, v.addr});
    chk({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, v.we});
    if (v.we) chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, {24'd0, v.wdata});
    chk({tag, "_ack_in_mem"}, {30'd0, m1_ack, m0_ack}, 32'd0);
    @(negedge clk);
    chk({tag, "_ack"}, {30'd0, m1_ack, m0_ack}, v.mst ? 32'd2 : 32'd1);
    chk({tag, "_we_in_ack"}, {31'd0, mem_we}, 32'd0);
    if (v.chk_rd) chk({tag, "_rdata"}, {24'd0, rdata}, {24'd0, v.exp_rdata});
    clear_reqs();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 12'h123, 8'h00, 1'b1, 8'h5A};
    vecs[1] = '{1'b1, 1'b1, 12'hD10, 8'h77, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 12'hD10, 8'h00, 1'b1, 8'h77};
    vecs[3] = '{1'b1, 1'b1, 12'h000, 8'hA5, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 12'h000, 8'h00, 1'b1, 8'hA5};
    vecs[5] = '{1'b0, 1'b1, 12'hFFF, 8'h3C, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 12'hFFF, 8'h00, 1'b1, 8'h3C};
    vecs[7] = '{1'b0, 1'b0, 12'h123, 8'h00, 1'b1, 8'h5A};

    clear_reqs();
    reset   = 1'b1;
    preload = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    reset   = 1'b0;
    preload = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i], i);
    end

    // Tie after reset: M0 first, then strict alternation
    do_reset();
    m0_req = 1'b1; m0_addr = 12'h123;
    m1_req = 1'b1; m1_addr = 12'h123;
    for (int k = 1; k <= 12; k++) begin
      logic [1:0] e;
      @(negedge clk);
      e = (k % 3 == 2) ? (((k / 3) % 2 == 0) ? 2'd1 : 2'd2) : 2'd0;
      chk($sformatf("tie_k%0d", k), {30'd0, m1_ack, m0_ack}, {30'd0, e});
    end

    // Burst lock: four M0 grants then one M1, then M0 alone every 3 cycles
    do_reset();
    m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 12'h010;
    m1_req = 1'b1; m1_addr = 12'h020;
    for (int k = 1; k <= 39; k++) begin
      logic [1:0] e;
      @(negedge clk);
      if (k % 3 == 2) e = (k <= 30 && (((k - 2) / 3) % 5 == 4)) ? 2'd2 : 2'd1;
      else e = 2'd0;
      chk($sformatf("burst_k%0d", k), {30'd0, m1_ack, m0_ack}, {30'd0, e});
      if (k == 30) m1_req = 1'b0;
    end

    // Reset in the middle of a write: outputs drop at once and RAM keeps old data
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'h456; m1_wdata = 8'h99;
    @(negedge clk);
    wait_mem("rstwr");
    chk("rstwr_we_before", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstwr_we", {31'd0, mem_we}, 32'd0);
    chk("rstwr_busy", {31'd0, busy}, 32'd0);
    chk("rstwr_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rstwr_addr", {20'd0, mem_addr}, 32'd0);
    clear_reqs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rstwr_ram", {24'd0, ram[12'h456]}, 32'h11);
    m0_req = 1'b1; m0_addr = 12'h123;
    m1_req = 1'b1; m1_addr = 12'h123;
    for (int k = 1; k <= 5; k++) begin
      logic [1:0] e;
      @(negedge clk);
      e = (k == 2) ? 2'd1 : ((k == 5) ? 2'd2 : 2'd0);
      chk($sformatf("rstwr_tie_k%0d", k), {30'd0, m1_ack, m0_ack}, {30'd0, e});
    end

    // Waiting master changes its address before being sampled
    do_reset();
    m1_req = 1'b1; m1_addr = 12'h123;
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 12'h010;
    @(negedge clk);
    chk("stab_m1_ack", {30'd0, m1_ack, m0_ack}, 32'd2);
    chk("stab_m1_rdata", {24'd0, rdata}, 32'h5A);
    m1_req = 1'b0; m0_addr = 12'h020;
    @(negedge clk);
    chk("stab_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("stab_addr", {20'd0, mem_addr}, 32'h020);
    @(negedge clk);
    chk("stab_m0_ack", {30'd0, m1_ack, m0_ack}, 32'd1);
    chk("stab_m0_rdata", {24'd0, rdata}, 32'hC3);
    clear_reqs();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
